serial_add_ctrl: RTL and testbench
==================================

# serial_add_ctrl

Bit-serial adder controller that sequences a single 1-bit full-adder cell (the existing decoder-based FADDER) over WIDTH-bit operands, one bit per clock, LSB first. It latches operands on a start request, runs WIDTH add steps while holding a carry flop between steps, then presents the registered result with a one-cycle done pulse. It sits between a requesting control unit and the shared 1-bit adder datapath, trading latency for area.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- cin  input  1  carry-in; latched on accepted start.
- sub  input  1  subtract select; present only with SERIAL_ADD_SUB_EN.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in DONE.
- sum  output  WIDTH  result register.
- cout  output  1  final carry register.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 -> load shift regs A<=a, B<=b, carry flop<=cin, step counter<=0, go RUN. start=0 -> stay.
- RUN, each cycle: FADDER inputs x=A[0], y=B[0], z=carry; s shifted into result shift reg MSB (shift right); carry<=c; A,B shift right; counter+1.
- After step WIDTH-1 (counter==WIDTH-1): sum<=completed shift reg incl. final s bit, cout<=final c, go DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- sum/cout update only on RUN->DONE; hold value through IDLE and the next RUN.
- Counter width $clog2(WIDTH); no wrap occurs because exit is at WIDTH-1.
- start in RUN or DONE ignored, not queued; a/b/cin changes after acceptance have no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).

## Timing
- Reset values: state IDLE, busy=0, done=0, sum=0, cout=0, carry flop 0, counter 0, shift regs 0.
- rst has priority over all transitions; asserted mid-RUN aborts: next cycle IDLE, all outputs at reset values, partial result discarded.
- start sampled at edge T (IDLE): busy=1 for edges T+1..T+WIDTH; done=1, busy=0, sum/cout valid from T+WIDTH+1.
- Earliest next accepted start: edge T+WIDTH+2 (first IDLE cycle); throughput one op per WIDTH+2 cycles.
- busy and done never high together; both registered (decoded from state flops).

## Configuration
- SERIAL_ADD_SUB_EN defined: sub port exists; on accepted start with sub=1, B<=~b and carry<=1 (cin ignored), giving sum=a-b mod 2^WIDTH, cout=1 means no borrow (a>=b unsigned). sub=0 behaves as plain add.
- Undefined: no sub port; add only, as described above.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, cin=0, start at T -> busy T+1..T+8, done pulse at T+9, sum=0x8D, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
- start held high continuously with changing a/b during RUN -> result uses values latched at acceptance; next accept exactly at T+10.
- rst asserted at T+4 during RUN -> T+5: busy=0, done=0, sum=0x00, cout=0; subsequent start 0x01+0x01 -> sum=0x02.
- Back-to-back: result 0x8D held through next operation's RUN, replaced only at its done pulse.
- SERIAL_ADD_SUB_EN: 0x10-0x01 -> sum=0x0F, cout=1; 0x00-0x01 -> sum=0xFF, cout=0.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: drives one decoder-based full-adder cell over WIDTH bits, LSB first.
// Optional subtract mode is compiled in with `define SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // FADDER cell: one-hot minterm decode of {x,y,z}, returns {c, s}
  function automatic logic [1:0] fadder(input logic x, input logic y, input logic z);
    logic [7:0] m;
    m = 8'd1 << {x, y, z};
    fadder = {m[3] | m[5] | m[6] | m[7], m[1] | m[2] | m[4] | m[7]};
  endfunction

  state_t           state_r, next_state_s;
  logic [WIDTH-1:0] a_r, b_r, res_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             load_s, step_s, last_s;
  logic [WIDTH-1:0] b_load_s;
  logic             carry_load_s;
  logic [1:0]       fa_s;

  assign fa_s = fadder(a_r[0], b_r[0], carry_r);
  assign busy = (state_r == S_RUN);
  assign done = (state_r == S_DONE);

  // Next-state decode and per-cycle datapath controls
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    step_s       = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = S_RUN;
          load_s       = 1'b1;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_STEP) begin
          last_s       = 1'b1;
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_RUN;
        end
      end
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // Operand B and initial carry as loaded on acceptance (two's-complement subtract when enabled)
  always_comb begin
    b_load_s     = b;
    carry_load_s = cin;
`ifdef SERIAL_ADD_SUB_EN
    if (sub) begin
      b_load_s     = ~b;
      carry_load_s = 1'b1;
    end else begin
      b_load_s     = b;
      carry_load_s = cin;
    end
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Operand shift registers, carry flop, step counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      if (load_s) begin
        a_r     <= a;
        b_r     <= b_load_s;
        carry_r <= carry_load_s;
        cnt_r   <= '0;
      end else if (step_s) begin
        a_r     <= {1'b0, a_r[WIDTH-1:1]};
        b_r     <= {1'b0, b_r[WIDTH-1:1]};
        carry_r <= fa_s[1];
        res_r   <= {fa_s[0], res_r[WIDTH-1:1]};
        cnt_r   <= cnt_r + CW'(1);
      end
      // Result is published only when the final bit is produced
      if (last_s) begin
        sum  <= {fa_s[0], res_r[WIDTH-1:1]};
        cout <= fa_s[1];
      end
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: transaction-level model checked every cycle,
// directed literal cases, then randomized stimulus with occasional resets.
module tb_serial_add_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             cin = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub = 1'b0;
`endif
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 idle, 1 running, 2 done; result is pure arithmetic on the accepted operands
  int               m_phase = 0;
  int               m_left = 0;
  logic [WIDTH-1:0] m_sum = '0;
  logic             m_cout = 1'b0;
  logic [WIDTH:0]   m_pend = '0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                input logic ci, input logic s);
    if (s) ref_result = {(x >= y) ? 1'b1 : 1'b0, x - y};
    else   ref_result = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_left  <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase <= 1;
          m_left  <= WIDTH;
`ifdef SERIAL_ADD_SUB_EN
          m_pend  <= ref_result(a, b, cin, sub);
`else
          m_pend  <= ref_result(a, b, cin, 1'b0);
`endif
        end
        1: if (m_left == 1) begin
          m_phase <= 2;
          m_cout  <= m_pend[WIDTH];
          m_sum   <= m_pend[WIDTH-1:0];
        end else begin
          m_left <= m_left - 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, (m_phase == 1));
      check("done", done, (m_phase == 2));
      check("sum", sum, m_sum);
      check("cout", cout, m_cout);
      check("busy_done_excl", busy & done, 0);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("idle_bound", (busy || done), 0);
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic ci, input logic [WIDTH-1:0] hold,
                        input logic [WIDTH-1:0] es, input logic ec);
    int k = 0;
    wait_idle();
    a = x; b = y; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    check({name, "_hold"}, sum, hold);
    while (!done && k < WIDTH + 5) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, k, WIDTH);
    check({name, "_sum"}, sum, es);
    check({name, "_cout"}, cout, ec);
  endtask

  initial begin
    int second;
    logic prev_busy;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    rst = 1'b0;
    @(negedge clk);

    run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h00, 8'h8D, 1'b0);
    run_op("b2b_ff_01", 8'hFF, 8'h01, 1'b0, 8'h8D, 8'h00, 1'b1);
    run_op("ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'h00, 8'hFF, 1'b1);

    // start held high with operands changing every cycle
    wait_idle();
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    second = -1;
    prev_busy = busy;
    for (int j = 1; j <= WIDTH + 6; j++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      @(negedge clk);
      if (done) check("held_sum", sum, 8'h46);
      if (busy && !prev_busy && second < 0) second = j;
      prev_busy = busy;
    end
    check("held_reaccept", second, WIDTH + 2);
    start = 1'b0;

    // reset in the middle of a run
    wait_idle();
    a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    rst = 1'b0;
    run_op("after_rst", 8'h01, 8'h01, 1'b0, 8'h00, 8'h02, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b1;
    run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 8'h02, 8'h0F, 1'b1);
    run_op("sub_00_01", 8'h00, 8'h01, 1'b1, 8'h0F, 8'hFF, 1'b0);
    sub = 1'b0;
`endif

    // randomized traffic, every cycle checked against the model
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'($urandom);
`endif
      rst = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
